// File: rtl/fetch_stage.sv
// Fetch stage: program counter, instruction memory address and the IF/ID pipeline register.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-redirect trap).
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [63:0] pc_d,
    output logic [63:0] pc_plus4_d,
    output logic        valid_d,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        fetch_misalign,
`endif
    output logic [31:0] fetch_count
);

    logic [63:0] pc_q, pc_d_n;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [63:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] count_q, count_d;
    logic        misalign_q, misalign_d;
    logic [63:0] pc_plus4;

    assign pc_plus4  = pc_q + 64'd4;
    assign imem_addr = pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_d = misalign_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
`else
    assign misalign_d = 1'b0;
`endif

    // PC: a trapped fetch freezes the PC; otherwise redirect beats stall beats increment.
    always_comb begin
        pc_d_n = pc_q;
        if (misalign_q) begin
            pc_d_n = pc_q;
        end else if (redirect_valid) begin
            pc_d_n = redirect_pc;
        end else if (!stall_f) begin
            pc_d_n = pc_plus4;
        end
    end

    // IF/ID: flush beats stall; a trapped fetch only ever feeds bubbles.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        count_d      = count_q;
        if (flush_d) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (!stall_d) begin
            if (misalign_q) begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end else begin
                ifid_instr_d = imem_rd;
                ifid_pc_d    = pc_q;
                ifid_pc4_d   = pc_plus4;
                ifid_valid_d = 1'b1;
                count_d      = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 64'h0;
            ifid_pc4_q   <= 64'h0;
            ifid_valid_q <= 1'b0;
            count_q      <= 32'h0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d_n;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            count_q      <= count_d;
            misalign_q   <= misalign_d;
        end
    end

    assign instr_d     = ifid_instr_q;
    assign pc_d        = ifid_pc_q;
    assign pc_plus4_d  = ifid_pc4_q;
    assign valid_d     = ifid_valid_q;
    assign fetch_count = count_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps then random controls against a reference model.
module tb_fetch_stage;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [63:0] imem_addr, pc_d, pc_plus4_d;
    logic [31:0] imem_rd, instr_d, fetch_count;
    logic        valid_d;

    logic [63:0] w_imem_addr, w_pc_d, w_pc_plus4_d;
    logic [31:0] w_imem_rd, w_instr_d, w_fetch_count;
    logic        w_valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign, w_fetch_misalign;
`endif

    logic [31:0] mem [0:1023];
    assign imem_rd   = mem[imem_addr[11:2]];
    assign w_imem_rd = mem[w_imem_addr[11:2]];

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_rd(w_imem_rd),
        .stall_f(1'b0), .stall_d(1'b0), .flush_d(1'b0),
        .redirect_valid(1'b0), .redirect_pc(64'h0),
        .instr_d(w_instr_d), .pc_d(w_pc_d), .pc_plus4_d(w_pc_plus4_d), .valid_d(w_valid_d),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misalign(w_fetch_misalign),
`endif
        .fetch_count(w_fetch_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: the architectural view of PC and the IF/ID slot.
    logic [63:0] m_pc, m_pcd, m_pc4;
    logic [31:0] m_instr, m_cnt;
    logic        m_valid, m_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".imem_addr"}, imem_addr, m_pc);
        chk({ctx, ".instr_d"}, {32'h0, instr_d}, {32'h0, m_instr});
        chk({ctx, ".pc_d"}, pc_d, m_pcd);
        chk({ctx, ".pc_plus4_d"}, pc_plus4_d, m_pc4);
        chk({ctx, ".valid_d"}, {63'h0, valid_d}, {63'h0, m_valid});
        chk({ctx, ".fetch_count"}, {32'h0, fetch_count}, {32'h0, m_cnt});
`ifdef FETCH_MISALIGN_CHECK_EN
        chk({ctx, ".fetch_misalign"}, {63'h0, fetch_misalign}, {63'h0, m_mis});
`endif
    endtask

    task automatic step(input string ctx, input logic r, input logic sf, input logic sd,
                        input logic fl, input logic rv, input logic [63:0] rp);
        logic [31:0] word;
        rst = r; stall_f = sf; stall_d = sd; flush_d = fl;
        redirect_valid = rv; redirect_pc = rp;
        @(posedge clk);
        if (r) begin
            m_pc = 64'h0; m_instr = NOP; m_pcd = 64'h0; m_pc4 = 64'h0;
            m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
        end else begin
            word = mem[m_pc[11:2]];
            if (fl) begin
                m_instr = NOP; m_valid = 1'b0;
            end else if (!sd) begin
                if (m_mis) begin
                    m_instr = NOP; m_valid = 1'b0;
                end else begin
                    m_instr = word; m_pcd = m_pc; m_pc4 = m_pc + 64'd4;
                    m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            if (!m_mis) begin
                if (rv) m_pc = rp;
                else if (!sf) m_pc = m_pc + 64'd4;
            end
            if (rv && rp[1:0] != 2'b00) m_mis = 1'b1;
`else
            if (rv) m_pc = rp;
            else if (!sf) m_pc = m_pc + 64'd4;
`endif
        end
        #1;
        check_all(ctx);
    endtask

    initial begin
        logic [63:0] rp;
        m_pc = 64'h0; m_instr = NOP; m_pcd = 64'h0; m_pc4 = 64'h0;
        m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        step("reset0", 1, 0, 0, 0, 0, 64'h0);
        step("reset1", 1, 0, 0, 0, 0, 64'h0);
        chk("reset.valid_const", {63'h0, valid_d}, 64'h0);
        chk("reset.instr_const", {32'h0, instr_d}, {32'h0, NOP});
        chk("wrap.reset_addr", w_imem_addr, WRAP_PC);

        step("run1", 0, 0, 0, 0, 0, 64'h0);
        chk("run1.instr_word0", {32'h0, instr_d}, {32'h0, mem[0]});
        chk("wrap.addr_wrapped", w_imem_addr, 64'h0);
        chk("wrap.pc_d", w_pc_d, WRAP_PC);
        chk("wrap.pc_plus4_d", w_pc_plus4_d, 64'h0);
        step("run2", 0, 0, 0, 0, 0, 64'h0);
        chk("run2.addr8", imem_addr, 64'h8);

        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 1, 1, 0, 0, 64'h0);
            chk("stall.addr_hold", imem_addr, 64'h8);
            chk("stall.count_hold", {32'h0, fetch_count}, 64'd2);
        end
        step("resume", 0, 0, 0, 0, 0, 64'h0);
        chk("resume.addr12", imem_addr, 64'hC);
        chk("resume.count3", {32'h0, fetch_count}, 64'd3);

        step("to_0x10", 0, 0, 0, 0, 0, 64'h0);
        step("redirect", 0, 1, 0, 1, 1, 64'h40);
        chk("redirect.addr", imem_addr, 64'h40);
        chk("redirect.bubble", {32'h0, instr_d}, {32'h0, NOP});
        chk("redirect.valid", {63'h0, valid_d}, 64'h0);
        step("after_redirect", 0, 0, 0, 0, 0, 64'h0);
        chk("after_redirect.pc_d", pc_d, 64'h40);
        chk("after_redirect.valid", {63'h0, valid_d}, 64'h1);

        step("flush_vs_stall", 0, 0, 1, 1, 0, 64'h0);
        chk("flush_vs_stall.instr", {32'h0, instr_d}, {32'h0, NOP});
        chk("flush_vs_stall.valid", {63'h0, valid_d}, 64'h0);

        step("fstall_only", 0, 1, 0, 0, 0, 64'h0);
        step("fstall_only", 0, 1, 0, 0, 0, 64'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        step("mis_redirect", 0, 0, 0, 1, 1, 64'h42);
        chk("mis.flag", {63'h0, fetch_misalign}, 64'h1);
        chk("mis.addr", imem_addr, 64'h42);
        step("mis_hold", 0, 0, 0, 0, 0, 64'h0);
        chk("mis_hold.addr", imem_addr, 64'h42);
        chk("mis_hold.valid", {63'h0, valid_d}, 64'h0);
        step("mis_reset", 1, 0, 0, 0, 0, 64'h0);
        chk("mis_reset.flag", {63'h0, fetch_misalign}, 64'h0);
        chk("mis_reset.addr", imem_addr, 64'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            rp = {$urandom, $urandom};
`ifdef FETCH_MISALIGN_CHECK_EN
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
`else
            rp[1:0] = 2'b00;
`endif
            step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), rp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch-stage controller: holds the program counter and drives the asynchronous instruction memory address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Takes stall, flush and redirect controls from the hazard unit and the execute stage.
- Feeds the decode stage: instruction, PC, PC+4 and a valid bit.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (ADDI x0,x0,0) inserted on flush/reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  64  instruction memory address; combinational copy of the PC register.
- imem_rd  input  32  instruction from memory, valid in the same cycle as imem_addr.
- stall_f  input  1  hold the PC.
- stall_d  input  1  hold the IF/ID register.
- flush_d  input  1  load a bubble into the IF/ID register.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_pc  input  64  redirect target.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  64  IF/ID PC.
- pc_plus4_d  output  64  IF/ID PC+4.
- valid_d  output  1  IF/ID entry holds a real instruction.
- fetch_count  output  32  instructions accepted into IF/ID.

Behaviour:
- Reset (rst=1 at posedge):
  - pc <= RESET_PC.
  - instr_d <= NOP_INSTR; pc_d <= 0; pc_plus4_d <= 0; valid_d <= 0; fetch_count <= 0.
  - Reset has priority over all other inputs.
  - Reset mid-stall or mid-redirect discards that pending action.
- imem_addr = pc at all times; no extra latency. Memory indexes word pc[11:2].
- PC update, priority order per cycle:
  - 1. rst.
  - 2. redirect_valid: pc <= redirect_pc. Overrides stall_f.
  - 3. stall_f: pc holds.
  - 4. otherwise pc <= pc + 4. 64-bit add, wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
- IF/ID update, priority order per cycle:
  - 1. rst.
  - 2. flush_d: instr_d <= NOP_INSTR, valid_d <= 0; pc_d and pc_plus4_d hold. Overrides stall_d.
  - 3. stall_d: all IF/ID fields hold.
  - 4. otherwise: instr_d <= imem_rd; pc_d <= pc; pc_plus4_d <= pc + 4; valid_d <= 1.
- Redirect with flush_d: the hazard unit asserts flush_d in the same cycle as redirect_valid. The block does not self-flush.
- Single-cycle fetch: one instruction per cycle when no stall. Instruction at PC X appears on instr_d the cycle after imem_addr = X.
- fetch_count increments by 1 on every cycle that takes IF/ID path 4. Wraps at 2^32.
- stall_f=1 with stall_d=0 is legal. The IF/ID register re-captures the same PC each cycle.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output port fetch_misalign (1 bit, resets to 0).
  - When redirect_valid=1 and redirect_pc[1:0]!=0: pc still loads redirect_pc, and fetch_misalign is set to 1 (sticky until rst).
  - While fetch_misalign=1: the PC holds; IF/ID loads NOP_INSTR with valid_d=0 each non-stalled cycle; fetch_count does not increment.
- Not defined:
  - No port.
  - redirect_pc[1:0] is ignored for checking; the memory word index uses pc[11:2] as is.

Test Plan:
- Reset then free-run with memory returning words at 0,4,8 -> imem_addr 0,4,8,12 on consecutive cycles; instr_d/pc_d lag by one cycle; valid_d=1 from the 2nd cycle after reset release; fetch_count=3 after 3 captures.
- stall_f=1 and stall_d=1 for 3 cycles at pc=8 -> imem_addr stays 8; instr_d/pc_d/valid_d unchanged; fetch_count unchanged; resumes 8->12 after release.
- redirect_valid=1, redirect_pc=0x40, flush_d=1 while stall_f=1 at pc=0x10 -> next cycle imem_addr=0x40, instr_d=0x00000013, valid_d=0; following cycle pc_d=0x40, valid_d=1.
- flush_d=1 and stall_d=1 together -> instr_d=NOP_INSTR, valid_d=0 (flush wins).
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, free-run -> imem_addr wraps to 0; pc_plus4_d for the first capture = 0.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x42 -> fetch_misalign=1 next cycle; imem_addr holds 0x42; valid_d=0 thereafter; rst clears fetch_misalign to 0 and pc to RESET_PC.
